ysyx_22051013_hzd_ctrl: RTL and testbench
=========================================

Name: ysyx_22051013_hzd_ctrl

Overview:
Central pipeline hazard/sequencing controller for the 5-stage RV64 pipeline (IF/ID/EX/LS/WB). It merges ID load-use stall and jump requests, EX multi-cycle busy, IF/LS bus-outstanding status, and WB trap requests into per-stage stall/flush enables and a single PC redirect. It holds pending redirects across outstanding fetches and drains the bus before trap entry. It also keeps saturating stall and redirect performance counters.

Parameters:
PC_W, 64, PC / redirect address width
CNT_W, 32, width of stall_cnt and redir_cnt

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
id_stall_req  in  1  load-use hazard from ID
id_jump_req  in  1  ID misprediction/JALR redirect request
id_jump_pc  in  PC_W  ID redirect target
ex_busy  in  1  multi-cycle op (mul/div) occupying EX
if_busy  in  1  instruction fetch outstanding on bus
ls_busy  in  1  load/store outstanding on bus
trap_req  in  1  ecall/mret/interrupt committed in WB
trap_pc  in  PC_W  trap/return target
pc_stall  out  1  hold PC register
if_id_stall, id_ex_stall, ex_ls_stall, ls_wb_stall  out  1 each  hold stage register
if_id_flush, id_ex_flush, ex_ls_flush, ls_wb_flush  out  1 each  load bubble into stage register
redirect_valid  out  1  load redirect_pc into PC this cycle
redirect_pc  out  PC_W  redirect target, 0 when redirect_valid=0
stall_cnt  out  CNT_W  cycles with pc_stall=1
redir_cnt  out  CNT_W  cycles with redirect_valid=1

Behaviour:
- Reset (async, rst=1): state=RUN, pending PC regs=0, counters=0. All outputs are forced to 0 while rst=1.
- States: RUN, REDIR_WAIT, TRAP_DRAIN, TRAP_FLUSH. Outputs are combinational from state and inputs. Registers update on the clk rising edge.
- Stall and flush for the same stage are never both 1. Stall takes precedence, except in TRAP_FLUSH.
- RUN priority, highest first:
  1. trap_req: all four stall outputs and pc_stall are 1. Latch trap_pc. Next state TRAP_DRAIN.
  2. ls_busy: pc_stall, if_id, id_ex and ex_ls stalls are 1; ls_wb_flush=1.
  3. ex_busy: pc_stall, if_id and id_ex stalls are 1; ex_ls_flush=1.
  4. id_stall_req: pc_stall and if_id_stall are 1; id_ex_flush=1. A simultaneous id_jump_req is ignored because ID operands are invalid.
  5. id_jump_req with if_busy=0: redirect_valid=1, redirect_pc=id_jump_pc, if_id_flush=1. Stay in RUN.
  6. id_jump_req with if_busy=1: if_id_flush=1, pc_stall=1. Latch id_jump_pc. Next state REDIR_WAIT.
  7. Otherwise all outputs are 0.
- REDIR_WAIT:
  - pc_stall=1 and if_id_flush=1 every cycle, so the in-flight fetch is discarded.
  - When if_busy=0: redirect_valid=1 with the latched PC, pc_stall=0, next state RUN.
  - trap_req in this state: the trap path of RUN rule 1 applies and the pending jump is dropped.
  - id_jump_req is ignored here; ID is flushed.
- TRAP_DRAIN:
  - pc_stall and all four stage stalls are 1.
  - When ls_busy=0 and if_busy=0, next state TRAP_FLUSH.
  - trap_req is ignored.
- TRAP_FLUSH (exactly 1 cycle):
  - All four flush outputs are 1, all stalls are 0, redirect_valid=1, redirect_pc=latched trap_pc.
  - Next state RUN.
- Trap latency: trap_req at cycle N gives redirect at cycle N+2 minimum, plus one cycle per additional busy cycle.
- Counters:
  - stall_cnt increments on each cycle with pc_stall=1.
  - redir_cnt increments on each cycle with redirect_valid=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-sequence (any state) returns to RUN immediately. The pending jump or trap is discarded.

Test Plan:
- Load-use: id_stall_req=1 for 1 cycle in RUN -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for that cycle; stall_cnt 0->1.
- Jump with fetch idle: id_jump_req=1, id_jump_pc=0x80000100, if_busy=0 -> same cycle redirect_valid=1, redirect_pc=0x80000100, if_id_flush=1; redir_cnt=1.
- Jump during fetch: id_jump_req=1, pc=0x80000200, if_busy=1 held for 3 cycles -> REDIR_WAIT for 3 cycles with pc_stall=1 and if_id_flush=1. Redirect to 0x80000200 on the cycle if_busy falls.
- Trap during store: trap_req=1, trap_pc=0x80000004, ls_busy=1 for 2 more cycles -> all stages stalled. Then one cycle with all flushes, redirect_valid=1, redirect_pc=0x80000004.
- Priority: ls_busy=1 with ex_busy=1, id_stall_req=1 and id_jump_req=1 together -> only ls_busy response, no redirect. Trap arriving in REDIR_WAIT -> pending jump PC never appears.
- Saturation/reset: preload stall_cnt near max with CNT_W=4 and 20 stall cycles -> holds at 15. Assert rst in TRAP_DRAIN -> all outputs 0, state RUN, counters 0.

Source files
------------

// File: rtl/ysyx_22051013_hzd_ctrl_if.sv
// Hazard controller bundle: stage requests/bus status in, stall/flush/redirect out.
// master = pipeline side driving requests, slave = hazard controller.
interface ysyx_22051013_hzd_ctrl_if #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
);
    logic             id_stall_req;
    logic             id_jump_req;
    logic [PC_W-1:0]  id_jump_pc;
    logic             ex_busy;
    logic             if_busy;
    logic             ls_busy;
    logic             trap_req;
    logic [PC_W-1:0]  trap_pc;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_ls_stall;
    logic             ls_wb_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_ls_flush;
    logic             ls_wb_flush;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redir_cnt;

    modport master (
        output id_stall_req, id_jump_req, id_jump_pc, ex_busy,
        output if_busy, ls_busy, trap_req, trap_pc,
        input  pc_stall, if_id_stall, id_ex_stall, ex_ls_stall,
        input  ls_wb_stall, if_id_flush, id_ex_flush, ex_ls_flush,
        input  ls_wb_flush, redirect_valid, redirect_pc,
        input  stall_cnt, redir_cnt
    );

    modport slave (
        input  id_stall_req, id_jump_req, id_jump_pc, ex_busy,
        input  if_busy, ls_busy, trap_req, trap_pc,
        output pc_stall, if_id_stall, id_ex_stall, ex_ls_stall,
        output ls_wb_stall, if_id_flush, id_ex_flush, ex_ls_flush,
        output ls_wb_flush, redirect_valid, redirect_pc,
        output stall_cnt, redir_cnt
    );
endinterface

// File: rtl/ysyx_22051013_hzd_ctrl.sv
// Pipeline hazard controller: merges stage hazards into stall/flush/redirect.
// Ports: clk, rst (async high), bus (slave modport) carrying requests and controls.
module ysyx_22051013_hzd_ctrl #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    ysyx_22051013_hzd_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN,
        REDIR_WAIT,
        TRAP_DRAIN,
        TRAP_FLUSH
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [PC_W-1:0]  jump_pc_q;
    logic [PC_W-1:0]  trap_pc_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redir_cnt_q;

    // stage vectors ordered {if_id, id_ex, ex_ls, ls_wb}
    logic             pc_stall_c;
    logic [3:0]       stall_c;
    logic [3:0]       flush_c;
    logic             rv_c;
    logic [PC_W-1:0]  rpc_c;
    logic             jump_ld;
    logic             trap_ld;

    always_comb begin
        nxt        = state;
        pc_stall_c = 1'b0;
        stall_c    = 4'b0000;
        flush_c    = 4'b0000;
        rv_c       = 1'b0;
        rpc_c      = '0;
        jump_ld    = 1'b0;
        trap_ld    = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.trap_req) begin
                    pc_stall_c = 1'b1;
                    stall_c    = 4'b1111;
                    trap_ld    = 1'b1;
                    nxt        = TRAP_DRAIN;
                end else if (bus.ls_busy) begin
                    pc_stall_c = 1'b1;
                    stall_c    = 4'b1110;
                    flush_c    = 4'b0001;
                end else if (bus.ex_busy) begin
                    pc_stall_c = 1'b1;
                    stall_c    = 4'b1100;
                    flush_c    = 4'b0010;
                end else if (bus.id_stall_req) begin
                    // ID operands are stale, so any jump it raises is bogus
                    pc_stall_c = 1'b1;
                    stall_c    = 4'b1000;
                    flush_c    = 4'b0100;
                end else if (bus.id_jump_req && !bus.if_busy) begin
                    rv_c    = 1'b1;
                    rpc_c   = bus.id_jump_pc;
                    flush_c = 4'b1000;
                end else if (bus.id_jump_req) begin
                    // fetch in flight: park the target until the bus frees
                    pc_stall_c = 1'b1;
                    flush_c    = 4'b1000;
                    jump_ld    = 1'b1;
                    nxt        = REDIR_WAIT;
                end
            end
            REDIR_WAIT: begin
                if (bus.trap_req) begin
                    pc_stall_c = 1'b1;
                    stall_c    = 4'b1111;
                    trap_ld    = 1'b1;
                    nxt        = TRAP_DRAIN;
                end else begin
                    flush_c = 4'b1000;
                    if (!bus.if_busy) begin
                        rv_c  = 1'b1;
                        rpc_c = jump_pc_q;
                        nxt   = RUN;
                    end else begin
                        pc_stall_c = 1'b1;
                    end
                end
            end
            TRAP_DRAIN: begin
                pc_stall_c = 1'b1;
                stall_c    = 4'b1111;
                if (!bus.ls_busy && !bus.if_busy) begin
                    nxt = TRAP_FLUSH;
                end
            end
            TRAP_FLUSH: begin
                flush_c = 4'b1111;
                rv_c    = 1'b1;
                rpc_c   = trap_pc_q;
                nxt     = RUN;
            end
            default: nxt = RUN;
        endcase
    end

    // every control is held low while reset is asserted
    always_comb begin
        bus.pc_stall       = pc_stall_c & ~rst;
        bus.if_id_stall    = stall_c[3] & ~rst;
        bus.id_ex_stall    = stall_c[2] & ~rst;
        bus.ex_ls_stall    = stall_c[1] & ~rst;
        bus.ls_wb_stall    = stall_c[0] & ~rst;
        bus.if_id_flush    = flush_c[3] & ~rst;
        bus.id_ex_flush    = flush_c[2] & ~rst;
        bus.ex_ls_flush    = flush_c[1] & ~rst;
        bus.ls_wb_flush    = flush_c[0] & ~rst;
        bus.redirect_valid = rv_c & ~rst;
        bus.redirect_pc    = rst ? '0 : rpc_c;
        bus.stall_cnt      = stall_cnt_q;
        bus.redir_cnt      = redir_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            jump_pc_q   <= '0;
            trap_pc_q   <= '0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state <= nxt;
            if (jump_ld) jump_pc_q <= bus.id_jump_pc;
            if (trap_ld) trap_pc_q <= bus.trap_pc;
            if (pc_stall_c && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (rv_c && redir_cnt_q != '1)
                redir_cnt_q <= redir_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_22051013_hzd_ctrl.sv
// Directed bench for the hazard controller: vector table plus multi-cycle sequences.
// Control word = {pc_stall, 4 stalls, 4 flushes, redirect_valid}.
module tb_ysyx_22051013_hzd_ctrl;
    localparam int PC_W  = 64;
    localparam int CNT_W = 4;

    localparam logic [9:0] C_IDLE = 10'b0_0000_0000_0;
    localparam logic [9:0] C_LS   = 10'b1_1110_0001_0;
    localparam logic [9:0] C_EX   = 10'b1_1100_0010_0;
    localparam logic [9:0] C_LU   = 10'b1_1000_0100_0;
    localparam logic [9:0] C_JMP  = 10'b0_0000_1000_1;
    localparam logic [9:0] C_RW   = 10'b1_0000_1000_0;
    localparam logic [9:0] C_TRAP = 10'b1_1111_0000_0;
    localparam logic [9:0] C_TFL  = 10'b0_0000_1111_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22051013_hzd_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    ysyx_22051013_hzd_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [9:0] ctl = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall,
                      bus.ex_ls_stall, bus.ls_wb_stall, bus.if_id_flush,
                      bus.id_ex_flush, bus.ex_ls_flush, bus.ls_wb_flush,
                      bus.redirect_valid};

    typedef struct {
        logic            sr;
        logic            jr;
        logic [PC_W-1:0] jpc;
        logic            exb;
        logic            ifb;
        logic            lsb;
        logic [9:0]      ctl;
        logic [PC_W-1:0] rpc;
    } vec_t;

    task automatic drive(input logic sr, input logic jr, input logic [PC_W-1:0] jpc,
                         input logic exb, input logic ifb, input logic lsb,
                         input logic trap, input logic [PC_W-1:0] tpc);
        bus.id_stall_req = sr;
        bus.id_jump_req  = jr;
        bus.id_jump_pc   = jpc;
        bus.ex_busy      = exb;
        bus.if_busy      = ifb;
        bus.ls_busy      = lsb;
        bus.trap_req     = trap;
        bus.trap_pc      = tpc;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 0, 0, '0);
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [9:0] c, input logic [PC_W-1:0] rpc);
        #1;
        cmp({nm, " ctl"}, {54'd0, ctl}, {54'd0, c});
        cmp({nm, " rpc"}, bus.redirect_pc, rpc);
    endtask

    task automatic cnt(input string nm, input int s, input int r);
        cmp({nm, " stall_cnt"}, {60'd0, bus.stall_cnt}, 64'(s));
        cmp({nm, " redir_cnt"}, {60'd0, bus.redir_cnt}, 64'(r));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        #2;
        rst = 1'b0;
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, 0, 64'h0, 0, 0, 0, C_IDLE, 64'h0};
        tbl[1] = '{1, 0, 64'h0, 0, 0, 0, C_LU, 64'h0};
        tbl[2] = '{0, 1, 64'h8000_0100, 0, 0, 0, C_JMP, 64'h8000_0100};
        tbl[3] = '{1, 1, 64'h8000_0500, 1, 1, 1, C_LS, 64'h0};
        tbl[4] = '{1, 1, 64'h8000_0600, 1, 0, 0, C_EX, 64'h0};
        tbl[5] = '{1, 1, 64'h8000_0700, 0, 0, 0, C_LU, 64'h0};
        tbl[6] = '{0, 0, 64'h0, 0, 1, 0, C_IDLE, 64'h0};
        tbl[7] = '{0, 0, 64'h0, 0, 0, 1, C_LS, 64'h0};
        tbl[8] = '{0, 1, 64'hDEAD_BEEF_CAFE_0000, 0, 0, 0, C_JMP,
                   64'hDEAD_BEEF_CAFE_0000};

        // outputs must stay low during reset even with requests active
        drive(1, 1, 64'h1234, 1, 0, 1, 1, 64'h5678);
        chk("reset", C_IDLE, 64'h0);
        cnt("reset", 0, 0);
        #10;
        idle();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].sr, tbl[i].jr, tbl[i].jpc, tbl[i].exb,
                  tbl[i].ifb, tbl[i].lsb, 0, '0);
            chk($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].rpc);
            tick();
        end
        idle();
        cnt("table", 5, 2);

        // jump while a fetch is outstanding
        do_reset();
        drive(0, 1, 64'h8000_0200, 0, 1, 0, 0, '0);
        chk("rw enter", C_RW, 64'h0);
        tick();
        drive(0, 1, 64'h0000_1234, 0, 1, 0, 0, '0);
        chk("rw hold1", C_RW, 64'h0);
        tick();
        chk("rw hold2", C_RW, 64'h0);
        tick();
        drive(0, 0, '0, 0, 0, 0, 0, '0);
        chk("rw release", C_JMP, 64'h8000_0200);
        tick();
        chk("rw after", C_IDLE, 64'h0);
        cnt("rw", 3, 1);
        tick();

        // trap while a store drains; repeated trap_req must be ignored
        do_reset();
        drive(0, 0, '0, 0, 0, 1, 1, 64'h8000_0004);
        chk("trap enter", C_TRAP, 64'h0);
        tick();
        drive(0, 0, '0, 0, 0, 1, 1, 64'h0000_0099);
        chk("drain1", C_TRAP, 64'h0);
        tick();
        drive(0, 0, '0, 0, 0, 1, 0, '0);
        chk("drain2", C_TRAP, 64'h0);
        tick();
        idle();
        chk("drain3", C_TRAP, 64'h0);
        tick();
        chk("trap flush", C_TFL, 64'h8000_0004);
        tick();
        chk("trap after", C_IDLE, 64'h0);
        cnt("trap", 4, 1);
        tick();

        // minimum trap latency: redirect two cycles after trap_req
        do_reset();
        drive(0, 0, '0, 0, 0, 0, 1, 64'h8000_0010);
        chk("fast trap", C_TRAP, 64'h0);
        tick();
        idle();
        chk("fast drain", C_TRAP, 64'h0);
        tick();
        chk("fast flush", C_TFL, 64'h8000_0010);
        tick();

        // trap pre-empts a pending jump, whose target never shows up
        do_reset();
        drive(0, 1, 64'h8000_0300, 0, 1, 0, 0, '0);
        chk("pre rw", C_RW, 64'h0);
        tick();
        drive(0, 0, '0, 0, 1, 0, 1, 64'h8000_0008);
        chk("rw trap", C_TRAP, 64'h0);
        tick();
        idle();
        chk("rw drain", C_TRAP, 64'h0);
        tick();
        chk("rw tflush", C_TFL, 64'h8000_0008);
        tick();
        chk("rw no jump", C_IDLE, 64'h0);
        tick();

        // stall counter saturates at 15 with a 4-bit counter
        do_reset();
        drive(1, 0, '0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 20; i++) tick();
        idle();
        cnt("sat", 15, 0);

        // async reset in TRAP_DRAIN drops the trap
        do_reset();
        drive(0, 0, '0, 0, 0, 1, 1, 64'h8000_0020);
        tick();
        drive(0, 0, '0, 0, 0, 1, 0, '0);
        tick();
        rst = 1'b1;
        chk("rst drain", C_IDLE, 64'h0);
        cnt("rst drain", 0, 0);
        #2;
        rst = 1'b0;
        idle();
        chk("rst run", C_IDLE, 64'h0);
        tick();
        chk("rst run2", C_IDLE, 64'h0);
        cnt("rst run2", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
